// File: rtl/register_file_pkg.sv
// Shared constants for the 32 x 32 register file: default widths, the
// hardwired-zero register index and the register count.
package register_file_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_ADDR_WIDTH = 5;
    localparam int REG_ZERO           = 0;
    localparam int REG_COUNT          = 2 ** DEFAULT_ADDR_WIDTH;

endpackage

// File: rtl/register_file_if.sv
// Read/write bus of the register file. The datapath side (decode and
// write-back) is the master; the register file is the slave.
interface register_file_if #(
    parameter int DATA_WIDTH = register_file_pkg::DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = register_file_pkg::DEFAULT_ADDR_WIDTH
) ();

    logic [ADDR_WIDTH-1:0] read_address0;
    logic [ADDR_WIDTH-1:0] read_address1;
    logic [DATA_WIDTH-1:0] read_data0;
    logic [DATA_WIDTH-1:0] read_data1;
    logic                  write_enable;
    logic [ADDR_WIDTH-1:0] write_address;
    logic [DATA_WIDTH-1:0] write_data;

    modport master (
        output read_address0,
        output read_address1,
        input  read_data0,
        input  read_data1,
        output write_enable,
        output write_address,
        output write_data
    );

    modport slave (
        input  read_address0,
        input  read_address1,
        output read_data0,
        output read_data1,
        input  write_enable,
        input  write_address,
        input  write_data
    );

endinterface

// File: rtl/register_file_read_port.sv
// One asynchronous read port: selects an entry from the flattened array and
// forces register 0 to zero. Defining REGFILE_BYPASS_EN adds write-through.
module register_read_port
    import register_file_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
    input  logic [(2**ADDR_WIDTH)*DATA_WIDTH-1:0] regs_flat,
    input  logic [ADDR_WIDTH-1:0]                 read_address,
    input  logic                                  reset,
    input  logic                                  write_enable,
    input  logic [ADDR_WIDTH-1:0]                 write_address,
    input  logic [DATA_WIDTH-1:0]                 write_data,
    output logic [DATA_WIDTH-1:0]                 read_data
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] entries [DEPTH];

    for (genvar i = 0; i < DEPTH; i++) begin : g_unpack
        assign entries[i] = regs_flat[i*DATA_WIDTH +: DATA_WIDTH];
    end

`ifdef REGFILE_BYPASS_EN
    // The in-flight write-back value wins over storage, but never for r0
    // and never while reset is dropping that write.
    logic bypass_hit;
    assign bypass_hit = write_enable && !reset &&
                        (write_address != ADDR_WIDTH'(REG_ZERO)) &&
                        (write_address == read_address);

    always_comb begin
        read_data = '0;
        if (read_address == ADDR_WIDTH'(REG_ZERO))
            read_data = '0;
        else if (bypass_hit)
            read_data = write_data;
        else
            read_data = entries[read_address];
    end
`else
    logic unused_bypass;
    assign unused_bypass = ^{reset, write_enable, write_address, write_data};

    always_comb begin
        read_data = '0;
        if (read_address != ADDR_WIDTH'(REG_ZERO))
            read_data = entries[read_address];
    end
`endif

endmodule

// File: rtl/register_file.sv
// 32 x 32 register file: two asynchronous read ports, one synchronous write
// port, r0 hardwired to zero. REGFILE_BYPASS_EN enables write-through reads.
module register_file
    import register_file_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
    input logic            clock,
    input logic            reset,
    register_file_if.slave bus
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0]         regs [1:DEPTH-1];
    logic [DEPTH*DATA_WIDTH-1:0]   regs_flat;

    // Reset outranks a same-edge write; r0 has no storage, so writes to it vanish.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 1; i < DEPTH; i++)
                regs[i] <= '0;
        end else if (bus.write_enable && (bus.write_address != ADDR_WIDTH'(REG_ZERO))) begin
            regs[bus.write_address] <= bus.write_data;
        end
    end

    assign regs_flat[DATA_WIDTH-1:0] = '0;
    for (genvar i = 1; i < DEPTH; i++) begin : g_flatten
        assign regs_flat[i*DATA_WIDTH +: DATA_WIDTH] = regs[i];
    end

    register_read_port #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_read_port0 (
        .regs_flat     (regs_flat),
        .read_address  (bus.read_address0),
        .reset         (reset),
        .write_enable  (bus.write_enable),
        .write_address (bus.write_address),
        .write_data    (bus.write_data),
        .read_data     (bus.read_data0)
    );

    register_read_port #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_read_port1 (
        .regs_flat     (regs_flat),
        .read_address  (bus.read_address1),
        .reset         (reset),
        .write_enable  (bus.write_enable),
        .write_address (bus.write_address),
        .write_data    (bus.write_data),
        .read_data     (bus.read_data1)
    );

endmodule

// File: tb/tb_register_file.sv
// Scoreboard bench for register_file: directed and random cycles predicted by
// an array model, checked mid-cycle by an independent monitor.
module tb_register_file;
    import register_file_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b0;

    register_file_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) rf_bus ();

    register_file dut (
        .clock (clock),
        .reset (reset),
        .bus   (rf_bus)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [31:0] exp0;
        logic [31:0] exp1;
    } expect_t;

    expect_t     exp_queue  [$];
    string       name_queue [$];
    logic [31:0] model_regs [REG_COUNT];
    int          vectors_applied = 0;
    int          miscompares     = 0;

    function automatic logic [31:0] modelRead(input logic [4:0] ra, input logic rst,
                                              input logic we, input logic [4:0] wa,
                                              input logic [31:0] wd);
        if (ra == 5'd0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
        if (we && !rst && wa != 5'd0 && wa == ra) return wd;
`endif
        return model_regs[ra];
    endfunction

    // Drive one cycle, predict both read ports, then commit the write to the model.
    task automatic applyStimulus(input string name, input bit check, input logic rst,
                                 input logic we, input logic [4:0] wa, input logic [31:0] wd,
                                 input logic [4:0] ra0, input logic [4:0] ra1);
        expect_t e;
        reset                = rst;
        rf_bus.write_enable  = we;
        rf_bus.write_address = wa;
        rf_bus.write_data    = wd;
        rf_bus.read_address0 = ra0;
        rf_bus.read_address1 = ra1;
        if (check) begin
            e.exp0 = modelRead(ra0, rst, we, wa, wd);
            e.exp1 = modelRead(ra1, rst, we, wa, wd);
            exp_queue.push_back(e);
            name_queue.push_back(name);
        end
        @(posedge clock);
        if (rst) begin
            for (int i = 0; i < REG_COUNT; i++) model_regs[i] = 32'h0;
        end else if (we && wa != 5'd0) begin
            model_regs[wa] = wd;
        end
        #1;
    endtask

    task automatic checkOutput(input string name, input string port,
                               input logic [31:0] actual, input logic [31:0] required);
        vectors_applied++;
        if (actual !== required) begin
            miscompares++;
            $display("[TB] FAIL %s.%s actual=%08h required=%08h", name, port, actual, required);
        end
    endtask

    // Monitor: read ports are combinational, so every cycle presents data mid-cycle.
    initial begin
        expect_t e;
        string   n;
        forever begin
            @(negedge clock);
            if (exp_queue.size() > 0) begin
                e = exp_queue.pop_front();
                n = name_queue.pop_front();
                checkOutput(n, "rd0", rf_bus.read_data0, e.exp0);
                checkOutput(n, "rd1", rf_bus.read_data1, e.exp1);
            end
        end
    end

    initial begin
        int drain;
        for (int i = 0; i < REG_COUNT; i++) model_regs[i] = 32'h0;
        reset                = 1'b1;
        rf_bus.write_enable  = 1'b0;
        rf_bus.write_address = '0;
        rf_bus.write_data    = '0;
        rf_bus.read_address0 = '0;
        rf_bus.read_address1 = '0;
        @(posedge clock);
        #1;

        applyStimulus("init_reset", 0, 1, 0, 0, 0, 0, 0);
        for (int a = 0; a < REG_COUNT; a++)
            applyStimulus("reset_state", 1, 0, 0, 0, 0, 5'(a), 5'(31 - a));

        applyStimulus("basic_wr", 1, 0, 1, 5, 32'hDEADBEEF, 5, 5);
        applyStimulus("basic_rd", 1, 0, 0, 0, 0, 5, 5);

        applyStimulus("zero_wr", 1, 0, 1, 0, 32'hFFFFFFFF, 0, 1);
        applyStimulus("zero_rd", 1, 0, 0, 0, 0, 0, 1);

        applyStimulus("rst_vs_wr", 1, 1, 1, 7, 32'h12345678, 7, 5);
        applyStimulus("rst_vs_wr_rd", 1, 0, 0, 0, 0, 7, 5);

        applyStimulus("raw_setup", 1, 0, 1, 9, 32'h00000011, 9, 0);
        applyStimulus("raw_same", 1, 0, 1, 9, 32'h00000022, 9, 9);
        applyStimulus("raw_after", 1, 0, 0, 0, 0, 9, 9);

        for (int i = 1; i < REG_COUNT; i++)
            applyStimulus("sweep_wr", 1, 0, 1, 5'(i), 32'(i) * 32'h01010101, 0, 5'(i));
        for (int i = 0; i < REG_COUNT; i++)
            applyStimulus("sweep_rd", 1, 0, 0, 0, 0, 5'(i), 5'(31 - i));

        for (int c = 0; c < 400; c++)
            applyStimulus("random", 1, ($urandom_range(31) == 0), $urandom_range(1),
                          5'($urandom_range(31)), $urandom, 5'($urandom_range(31)),
                          5'($urandom_range(31)));

        applyStimulus("late_reset", 1, 1, 0, 0, 0, 3, 4);
        for (int a = 0; a < REG_COUNT; a++)
            applyStimulus("reset_again", 1, 0, 0, 0, 0, 5'(a), 5'(a));

        drain = 0;
        while (exp_queue.size() > 0 && drain < 20) begin
            @(posedge clock);
            drain++;
        end
        if (exp_queue.size() > 0) begin
            miscompares++;
            $display("[TB] FAIL drain pending=%0d required=0", exp_queue.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end

endmodule

// File: doc/register_file.md
Name: register_file

Overview:
- 32-entry x 32-bit general-purpose register file for the single-issue integer datapath.
- Two asynchronous read ports feed the ALU operand select muxes (rs -> A-side, rt -> B-side/immediate select); one synchronous write port is driven from write-back.
- Register 0 is hardwired to zero.

Parameters:
- DATA_WIDTH, 32, width of each register and of all data ports.
- ADDR_WIDTH, 5, register address width; depth = 2**ADDR_WIDTH.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- read_address0  input  ADDR_WIDTH  read port 0 index (rs).
- read_address1  input  ADDR_WIDTH  read port 1 index (rt).
- read_data0  output  DATA_WIDTH  contents of read_address0.
- read_data1  output  DATA_WIDTH  contents of read_address1.
- write_enable  input  1  commit write_data on this clock edge.
- write_address  input  ADDR_WIDTH  write index (rd/rt from write-back).
- write_data  input  DATA_WIDTH  value to write.

Behaviour:
- Storage: registers 1..2**ADDR_WIDTH-1 are flops; register 0 has no storage.
- Reset is synchronous, active-high:
  - On a rising clock edge with reset=1, every register is cleared to 0.
  - reset has priority over write_enable in the same cycle; the write is dropped.
  - No asynchronous path exists; reset asserted between edges has no effect until the next edge.
- Write: on a rising edge with reset=0, write_enable=1 and write_address!=0, regs[write_address] <= write_data. The value is visible on read ports from the following cycle (one-cycle write latency).
- Write to address 0 is silently discarded. read_data for address 0 is always 0, including under bypass.
- Read:
  - Combinational; read_dataN = regs[read_addressN] with zero clock latency.
  - Output changes follow address changes in the same cycle.
  - Outputs after reset: 0 for every address.
- Simultaneous events:
  - Both read ports may address the same register and get identical data.
  - A read of the address being written in the same cycle returns the OLD value unless REGFILE_BYPASS_EN is defined.
- No state machine and no handshake; the write port is fire-and-forget, and the block never stalls.
- Widths are exact. No sign or zero extension happens inside the block.

Optional Feature:
- Macro: REGFILE_BYPASS_EN
- Defined: write-through bypass. For each read port, if write_enable=1, write_address!=0, reset=0 and write_address==read_addressN, then read_dataN = write_data combinationally in that same cycle. This removes the write-back -> decode hazard and its forwarding path.
- Not defined: no bypass. Reads return stored contents only, and same-cycle read-after-write sees the previous value.

Decomposition:
- Shared package / include: DATA_WIDTH and ADDR_WIDTH defaults, a REG_ZERO constant (0), and a REG_COUNT constant (2**ADDR_WIDTH).
- Sub-module register_read_port, instantiated twice:
  - Inputs: the flattened register array, a read address, and the bypass inputs.
  - Behaviour: applies the zero-register override and the optional bypass compare.
- The top level holds storage, the reset/write logic, and the two read_port instances.

Test Plan:
- Reset: drive reset=1 for one edge after arbitrary prior writes -> all 32 addresses read 0x00000000 on both ports.
- Basic write/read: write 0xDEADBEEF to r5, then on the next cycle set read_address0=5 and read_address1=5 -> both read_data = 0xDEADBEEF.
- Zero register: write 0xFFFFFFFF to r0, then read r0 -> 0x00000000; r1..r31 unchanged.
- Reset vs write: write_enable=1, write_address=7, write_data=0x12345678 with reset=1 on the same edge -> r7 reads 0x00000000 afterwards.
- Same-cycle read-after-write: r9=0x00000011, then in one cycle write 0x00000022 to r9 while read_address0=9:
  - Without REGFILE_BYPASS_EN: read_data0=0x00000011 in that cycle, then 0x00000022.
  - With REGFILE_BYPASS_EN: 0x00000022 in that same cycle.
- Sweep: write i*0x01010101 to each ri (i=1..31), then read all pairs (i, 31-i) -> exact values, and r0 = 0.
